async_fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter for async_fifo_top, in the write clock domain.

---
 rtl/async_fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants last up to BURST_MAX beats; a full FIFO stalls the grant without revoking it.
module async_fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2,
    parameter int BURST_MAX  = 4,
    parameter int CNT_W      = 2
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [IDX_W-1:0]              owner,
    output logic                          busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] last_owner_reg, last_owner_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic [DATA_WIDTH-1:0] word [NUM_REQ];
    logic [IDX_W-1:0]      pick;
    logic                  pick_found;
    logic                  owner_valid;
    logic                  owner_req;
    logic                  accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Search starts just after the previous owner, so it ends up lowest priority.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(last_owner_reg) + k) % NUM_REQ;
            if (!pick_found && req[cand]) begin
                pick       = IDX_W'(cand);
                pick_found = 1'b1;
            end
        end
    end

    assign owner_valid = (int'(owner_reg) < NUM_REQ);
    assign owner_req   = owner_valid ? req[owner_reg] : 1'b0;
    assign accept      = (state_reg == GRANT) && owner_req && !full;

    assign w_en    = accept;
    assign ack     = accept ? (NUM_REQ'(1) << owner_reg) : '0;
    assign data_in = accept ? word[owner_reg] : '0;
    assign owner   = owner_reg;
    assign busy    = (state_reg == GRANT);

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    owner_next    = pick;
                    beat_cnt_next = '0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_next = IDLE;
                end else if (!owner_req) begin
                    // Dropped request ends the tenure even while the FIFO is full.
                    last_owner_next = owner_reg;
                    state_next      = IDLE;
                end else if (!full) begin
                    if (beat_cnt_reg == CNT_W'(BURST_MAX - 1)) begin
                        last_owner_next = owner_reg;
                        state_next      = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: reset, bursts, rotation, full stall, early release.
module tb_async_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [31:0] req_data;
    logic        full = 1'b0;
    logic [3:0]  ack;
    logic        w_en;
    logic [7:0]  data_in;
    logic [1:0]  owner;
    logic        busy;

    int cnt [4];
    int checks = 0;
    int errors = 0;

    always #5 wclk = ~wclk;

    // Requester i presents 8'hA0 + 16*i + (words already consumed).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_data
            assign req_data[gi*8 +: 8] = 8'(8'hA0 + 16*gi + cnt[gi]);
        end
    endgenerate

    async_fifo_wr_arbiter #(
        .DATA_WIDTH(8), .NUM_REQ(4), .IDX_W(2), .BURST_MAX(4), .CNT_W(2)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .full(full),
        .ack(ack), .w_en(w_en), .data_in(data_in), .owner(owner), .busy(busy)
    );

    task automatic apply_reset();
        req = 4'h0;
        full = 1'b0;
        wrst_n = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        foreach (cnt[i]) cnt[i] = 0;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'hF;
        #3 wrst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({busy, w_en, ack, data_in, owner} !== 16'h0) begin
                errors++;
                $display("FAIL reset c%0d: busy=%b w_en=%b ack=%b data=%h owner=%0d want all 0",
                         c, busy, w_en, ack, data_in, owner);
            end
            @(posedge wclk);
            #1;
        end
        foreach (cnt[i]) cnt[i] = 0;
        req = 4'h0;
        wrst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [0:10] wen_p = 11'b01111011110;
        int nwr = 0;
        apply_reset();
        req = 4'b0001;
        for (int c = 0; c < 11; c++) begin
            logic       ew;
            logic [3:0] ea;
            logic [7:0] ed;
            #2;
            ew = wen_p[c];
            ea = ew ? 4'b0001 : 4'b0000;
            ed = ew ? 8'(8'hA0 + nwr) : 8'h00;
            checks++;
            if ({busy, w_en, ack, data_in} !== {ew, ew, ea, ed}) begin
                errors++;
                $display("FAIL single c%0d: busy=%b w_en=%b ack=%b data=%h want busy=%b w_en=%b ack=%b data=%h",
                         c, busy, w_en, ack, data_in, ew, ew, ea, ed);
            end
            @(posedge wclk);
            #1;
            if (ew) begin
                cnt[0]++;
                nwr++;
            end
        end
    endtask

    task automatic test_all();
        int beats [4] = '{0, 0, 0, 0};
        int nw = 0;
        apply_reset();
        req = 4'hF;
        for (int c = 0; c < 20; c++) begin
            logic       ew;
            logic [3:0] ea;
            logic [7:0] ed;
            int         o;
            #2;
            o  = (c / 5) % 4;
            ew = (c % 5) != 0;
            ea = ew ? 4'(1 << o) : 4'h0;
            ed = ew ? 8'(8'hA0 + 16*o + beats[o]) : 8'h00;
            checks++;
            if ({busy, w_en, ack, data_in} !== {ew, ew, ea, ed} || (ew && owner !== 2'(o))) begin
                errors++;
                $display("FAIL all c%0d: busy=%b w_en=%b ack=%b data=%h owner=%0d want busy=%b w_en=%b ack=%b data=%h owner=%0d",
                         c, busy, w_en, ack, data_in, owner, ew, ew, ea, ed, o);
            end
            if (w_en) nw++;
            @(posedge wclk);
            #1;
            if (ew) begin
                cnt[o]++;
                beats[o]++;
            end
        end
        checks++;
        if (nw !== 16) begin
            errors++;
            $display("FAIL all write count: got %0d want 16", nw);
        end
    endtask

    task automatic test_full_stall();
        logic [0:8] full_p = 9'b000111000;
        logic [0:8] wen_p  = 9'b011000110;
        logic [0:8] busy_p = 9'b011111110;
        int k = 0;
        apply_reset();
        req = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            logic       ew;
            logic       eb;
            logic [3:0] ea;
            logic [7:0] ed;
            full = full_p[c];
            #2;
            ew = wen_p[c];
            eb = busy_p[c];
            ea = ew ? 4'b0010 : 4'b0000;
            ed = ew ? 8'(8'hB0 + k) : 8'h00;
            checks++;
            if ({busy, w_en, ack, data_in} !== {eb, ew, ea, ed} || (eb && owner !== 2'd1)) begin
                errors++;
                $display("FAIL full_stall c%0d: busy=%b w_en=%b ack=%b data=%h owner=%0d want busy=%b w_en=%b ack=%b data=%h owner=1",
                         c, busy, w_en, ack, data_in, owner, eb, ew, ea, ed);
            end
            @(posedge wclk);
            #1;
            if (ew) begin
                cnt[1]++;
                k++;
            end
        end
        full = 1'b0;
    endtask

    task automatic test_early_release();
        logic [0:8] busy_p = 9'b011011110;
        logic [0:8] wen_p  = 9'b010011110;
        int         own_p [9] = '{0, 2, 2, 0, 3, 3, 3, 3, 0};
        int beats [4] = '{0, 0, 0, 0};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            logic       ew;
            logic       eb;
            logic [3:0] ea;
            logic [7:0] ed;
            int         o;
            req = (c < 2) ? 4'b1100 : 4'b1000;
            #2;
            o  = own_p[c];
            ew = wen_p[c];
            eb = busy_p[c];
            ea = ew ? 4'(1 << o) : 4'h0;
            ed = ew ? 8'(8'hA0 + 16*o + beats[o]) : 8'h00;
            checks++;
            if ({busy, w_en, ack, data_in} !== {eb, ew, ea, ed} || (eb && owner !== 2'(o))) begin
                errors++;
                $display("FAIL early_release c%0d: busy=%b w_en=%b ack=%b data=%h owner=%0d want busy=%b w_en=%b ack=%b data=%h owner=%0d",
                         c, busy, w_en, ack, data_in, owner, eb, ew, ea, ed, o);
            end
            @(posedge wclk);
            #1;
            if (ew) begin
                cnt[o]++;
                beats[o]++;
            end
        end
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        req = 4'b0110;
        // Owner 1 runs a full tenure (c1..c4), bubble at c5, owner 2 starts at c6.
        repeat (6) begin
            #2;
            if (w_en) cnt[owner]++;
            @(posedge wclk);
            #1;
        end
        #2;
        checks++;
        if ({busy, w_en, ack, owner} !== {1'b1, 1'b1, 4'b0100, 2'd2}) begin
            errors++;
            $display("FAIL midburst pre: busy=%b w_en=%b ack=%b owner=%0d want busy=1 w_en=1 ack=0100 owner=2",
                     busy, w_en, ack, owner);
        end
        @(posedge wclk);
        #1;
        cnt[2]++;
        #2 wrst_n = 1'b0;
        #1;
        checks++;
        if ({busy, w_en, ack, data_in, owner} !== 16'h0) begin
            errors++;
            $display("FAIL midburst async: busy=%b w_en=%b ack=%b data=%h owner=%0d want all 0",
                     busy, w_en, ack, data_in, owner);
        end
        @(posedge wclk);
        #1;
        checks++;
        if ({busy, w_en, ack, data_in, owner} !== 16'h0) begin
            errors++;
            $display("FAIL midburst held: busy=%b w_en=%b ack=%b data=%h owner=%0d want all 0",
                     busy, w_en, ack, data_in, owner);
        end
        wrst_n = 1'b1;
        #2;
        checks++;
        if ({busy, w_en} !== 2'b00) begin
            errors++;
            $display("FAIL midburst release idle: busy=%b w_en=%b want 0 0", busy, w_en);
        end
        @(posedge wclk);
        #3;
        checks++;
        if ({busy, w_en, ack, owner} !== {1'b1, 1'b1, 4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL midburst restart: busy=%b w_en=%b ack=%b owner=%0d want busy=1 w_en=1 ack=0010 owner=1",
                     busy, w_en, ack, owner);
        end
        req = 4'h0;
        @(posedge wclk);
        #1;
    endtask

    task automatic test_random_full();
        apply_reset();
        for (int c = 0; c < 200; c++) begin
            logic       bad;
            logic [7:0] ew_data;
            int         idx;
            req  = 4'($urandom_range(0, 7));
            full = ($urandom_range(0, 3) == 0);
            #2;
            bad = 1'b0;
            idx = 0;
            ew_data = 8'h00;
            for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
            if (w_en) ew_data = 8'(8'hA0 + 16*idx + cnt[idx]);
            if (w_en && full) bad = 1'b1;
            if (w_en && (ack != 4'(1 << idx) || !req[idx] || data_in !== ew_data)) bad = 1'b1;
            if (!w_en && (ack !== 4'h0 || data_in !== 8'h00)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL random c%0d: req=%b full=%b w_en=%b ack=%b data=%h want no write on full, one-hot ack to a requester, data=%h",
                         c, req, full, w_en, ack, data_in, ew_data);
            end
            @(posedge wclk);
            #1;
            if (w_en === 1'b0 && ack !== 4'h0) begin
                // nothing consumed
            end
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i]++;
        end
        req = 4'h0;
        full = 1'b0;
    endtask

    initial begin
        foreach (cnt[i]) cnt[i] = 0;
        test_reset();
        test_single();
        test_all();
        test_full_stall();
        test_early_release();
        test_reset_midburst();
        test_random_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
